// File: rtl/multiplier_controller_taint_track_if.sv
// Handshake/control bundle between the multiplier sequencer and its shift-add datapath.
// Each control line carries a companion _t taint bit.
interface multiplier_controller_taint_track_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             start_t;
    logic [WIDTH-1:0] multiplierReg;
    logic             multiplierReg_t;
    logic             busy;
    logic             busy_t;
    logic             done;
    logic             done_t;
    logic             mrld;
    logic             mrld_t;
    logic             mdld;
    logic             mdld_t;
    logic             rsclear;
    logic             rsclear_t;
    logic             rsload;
    logic             rsload_t;
    logic             rsshr;
    logic             rsshr_t;

    // Sequencer side
    modport slave (
        input  start, start_t, multiplierReg, multiplierReg_t,
        output busy, busy_t, done, done_t, mrld, mrld_t, mdld, mdld_t,
               rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t
    );

    // Requester / datapath side
    modport master (
        output start, start_t, multiplierReg, multiplierReg_t,
        input  busy, busy_t, done, done_t, mrld, mrld_t, mdld, mdld_t,
               rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t
    );
endinterface

// File: rtl/multiplier_controller_taint_track.sv
// Shift-add multiplier sequencer with control-flow taint propagation.
// Define MULT_CTRL_TAINT_EN to build the taint logic; otherwise every _t output is 0.
module multiplier_controller_taint_track #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    multiplier_controller_taint_track_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ITER  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy, done, mrld, mdld, rsclear, rsload, rsshr;
    logic          taint_now;
    logic          mr_bit;

    assign mr_bit = bus.multiplierReg[cnt_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;
        mrld    = 1'b0;
        mdld    = 1'b0;
        rsclear = 1'b0;
        rsload  = 1'b0;
        rsshr   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                busy    = 1'b1;
                mrld    = 1'b1;
                mdld    = 1'b1;
                rsclear = 1'b1;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (mr_bit) begin
                    rsload  = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    rsshr = 1'b1;
                    // cnt saturates at the last bit; the exit decision is made there
                    if (cnt_q == CNT_MAX) state_d = S_DONE;
                    else                  cnt_d   = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                busy  = 1'b1;
                rsshr = 1'b1;
                if (cnt_q == CNT_MAX) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_ITER;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MULT_CTRL_TAINT_EN
    logic ctrl_taint_q, ctrl_taint_d;

    // Sticky for the whole operation; reloaded only when a new start is accepted
    always_comb begin
        ctrl_taint_d = ctrl_taint_q;
        if (state_q == S_IDLE && bus.start)             ctrl_taint_d = bus.start_t;
        else if (state_q == S_ITER && bus.multiplierReg_t) ctrl_taint_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctrl_taint_q <= 1'b0;
        else        ctrl_taint_q <= ctrl_taint_d;
    end

    // An ITER cycle's branch is tainted by the multiplier bit it reads
    assign taint_now = ctrl_taint_q || (state_q == S_ITER && bus.multiplierReg_t);
`else
    logic unused_taint_in;
    assign unused_taint_in = bus.start_t ^ bus.multiplierReg_t;
    assign taint_now       = 1'b0;
`endif

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.mrld      = mrld;
    assign bus.mdld      = mdld;
    assign bus.rsclear   = rsclear;
    assign bus.rsload    = rsload;
    assign bus.rsshr     = rsshr;
    assign bus.busy_t    = busy    & taint_now;
    assign bus.done_t    = done    & taint_now;
    assign bus.mrld_t    = mrld    & taint_now;
    assign bus.mdld_t    = mdld    & taint_now;
    assign bus.rsclear_t = rsclear & taint_now;
    assign bus.rsload_t  = rsload  & taint_now;
    assign bus.rsshr_t   = rsshr   & taint_now;
endmodule

// File: tb/tb_multiplier_controller_taint_track.sv
// Directed bench: per-cycle control trace, taint and product checks against a
// behavioural shift-add datapath model driven by the sequencer outputs.
module tb_multiplier_controller_taint_track;
    localparam int W = 4;
`ifdef MULT_CTRL_TAINT_EN
    localparam bit TAINT_EN = 1'b1;
`else
    localparam bit TAINT_EN = 1'b0;
`endif
    // {busy, done, mrld, mdld, rsclear, rsload, rsshr}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_LOAD = 7'b1011100;
    localparam logic [6:0] C_ADD  = 7'b1000010;
    localparam logic [6:0] C_SHR  = 7'b1000001;
    localparam logic [6:0] C_DONE = 7'b1100000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    multiplier_controller_taint_track_if #(.WIDTH(W)) bus ();

    multiplier_controller_taint_track #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Datapath model
    logic [W-1:0] md_in;
    logic [W-1:0] md_q;
    logic [2*W:0] rs_q;

    always @(posedge clk) begin
        if (bus.mdld) md_q <= md_in;
        if (bus.rsclear)     rs_q <= '0;
        else if (bus.rsshr)  rs_q <= rs_q >> 1;
        else if (bus.rsload) rs_q <= rs_q + ((2*W+1)'(md_q) << W);
    end

    function automatic logic [6:0] ctl_obs();
        return {bus.busy, bus.done, bus.mrld, bus.mdld, bus.rsclear, bus.rsload, bus.rsshr};
    endfunction

    function automatic logic [6:0] tnt_obs();
        return {bus.busy_t, bus.done_t, bus.mrld_t, bus.mdld_t, bus.rsclear_t,
                bus.rsload_t, bus.rsshr_t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation; poke>0 re-pulses start in that cycle (must be ignored)
    task automatic run_op(input string tag, input logic [W-1:0] mr, input logic [W-1:0] md,
                          input logic st_t, input logic mr_t, input int poke);
        logic [6:0] trace [0:3*W+4];
        int         len;
        int         pop;
        int         done_k;
        logic       tnt;
        len = 1;
        pop = 0;
        done_k = -1;
        trace[1] = C_LOAD;
        for (int i = 0; i < W; i++) begin
            if (mr[i]) begin
                pop++;
                len++;
                trace[len] = C_ADD;
            end
            len++;
            trace[len] = C_SHR;
        end
        len++;
        trace[len] = C_DONE;

        @(negedge clk);
        bus.start           = 1'b1;
        bus.start_t         = st_t;
        bus.multiplierReg   = mr;
        bus.multiplierReg_t = mr_t;
        md_in               = md;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start   = 1'b0;
                bus.start_t = 1'b0;
            end
            tnt = TAINT_EN && (st_t || (mr_t && k >= 2));
            chk($sformatf("%s ctl[%0d]", tag, k), 32'(ctl_obs()), 32'(trace[k]));
            chk($sformatf("%s taint[%0d]", tag, k), 32'(tnt_obs()), 32'(trace[k] & {7{tnt}}));
            chk($sformatf("%s excl[%0d]", tag, k), 32'(bus.rsload & (bus.rsshr | bus.rsclear)), 32'd0);
            if (bus.done && done_k < 0) done_k = k;
            if (poke > 0 && k == poke)     bus.start = 1'b1;
            if (poke > 0 && k == poke + 1) bus.start = 1'b0;
        end
        // edges after the start-sampling edge until done is visible
        chk({tag, " latency"}, 32'(done_k - 1), 32'(1 + W + pop));
        chk({tag, " product"}, 32'(rs_q[2*W-1:0]), 32'(mr) * 32'(md));
        @(negedge clk);
        chk({tag, " idle"}, 32'({ctl_obs(), tnt_obs()}), 32'd0);
        bus.multiplierReg_t = 1'b0;
    endtask

    initial begin
        bus.start           = 1'b0;
        bus.start_t         = 1'b0;
        bus.multiplierReg   = '0;
        bus.multiplierReg_t = 1'b0;
        md_in               = '0;
        repeat (2) @(negedge clk);
        chk("reset outputs", 32'({ctl_obs(), tnt_obs()}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset idle", 32'({ctl_obs(), tnt_obs()}), 32'd0);

        run_op("t1 11x13", 4'b1011, 4'd13, 1'b0, 1'b0, 0);
        run_op("t2 0x15",  4'b0000, 4'd15, 1'b0, 1'b0, 0);
        run_op("t3 15x15", 4'b1111, 4'd15, 1'b0, 1'b0, 0);
        run_op("t4 start_t", 4'b1011, 4'd13, 1'b1, 1'b0, 0);
        run_op("t4 clean",   4'b1011, 4'd13, 1'b0, 1'b0, 0);
        run_op("t4 mr_t",    4'b0110, 4'd5,  1'b0, 1'b1, 0);
        run_op("t4 after mr_t", 4'b0110, 4'd5, 1'b0, 1'b0, 0);
        run_op("t5 poke", 4'b1011, 4'd13, 1'b0, 1'b0, 3);

        // Abort mid-ITER with a tainted start
        @(negedge clk);
        bus.start         = 1'b1;
        bus.start_t       = 1'b1;
        bus.multiplierReg = 4'b1011;
        md_in             = 4'd9;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.start_t = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5 pre-abort busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5 abort outputs", 32'({ctl_obs(), tnt_obs()}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t5 after reset", 4'b0111, 4'd6, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
